// File: rtl/pc_sequencer.sv
// Program-counter stage: PC register, branch resolution, next-PC select,
// RUN/HALT/FAULT control and a retired-instruction counter.
module pc_sequencer #(
   parameter int             N            = 32,
   parameter logic [N-1:0]   RESET_VECTOR = '0,
   parameter int             CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             branch,
   input  logic             jal,
   input  logic             jalr,
   input  logic             halt_req,
   input  logic [2:0]       funct3,
   input  logic             zf,
   input  logic             cf,
   input  logic             vf,
   input  logic             sf,
   input  logic [N-1:0]     imm,
   input  logic [N-1:0]     rs1_data,
   input  logic             resume,
   output logic [N-1:0]     pc,
   output logic [N-1:0]     pc_plus4,
   output logic [1:0]       pc_src,
   output logic             take_branch,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_e;

   localparam logic [1:0] SRC_SEQ  = 2'b00;
   localparam logic [1:0] SRC_JALR = 2'b01;
   localparam logic [1:0] SRC_BR   = 2'b10;
   localparam logic [1:0] SRC_HOLD = 2'b11;

   state_e           state_q, state_d;
   logic [N-1:0]     pc_q, pc_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic         cond;
   logic [N-1:0] br_tgt, jalr_sum, jalr_tgt, sel_tgt;

   always_comb begin
      cond = 1'b0;
      case (funct3)
         3'b000:  cond = zf;
         3'b001:  cond = ~zf;
         3'b100:  cond = sf ^ vf;
         3'b101:  cond = ~(sf ^ vf);
         3'b110:  cond = ~cf;
         3'b111:  cond = cf;
         default: cond = 1'b0;
      endcase
   end

   assign take_branch = branch & cond & (state_q == S_RUN);
   assign pc_plus4    = pc_q + N'(4);
   assign br_tgt      = pc_q + imm;
   assign jalr_sum    = rs1_data + imm;
   assign jalr_tgt    = {jalr_sum[N-1:1], 1'b0};

   always_comb begin
      pc_src    = SRC_HOLD;
      sel_tgt   = pc_q;
      pc_d      = pc_q;
      state_d   = state_q;
      instret_d = instret_q;
      case (state_q)
         S_RUN: begin
            if (halt_req) begin
               // Halt outranks every redirect, so no alignment check applies.
               state_d   = S_HALT;
               instret_d = instret_q + CNT_W'(1);
            end else begin
               if (jalr) begin
                  pc_src  = SRC_JALR;
                  sel_tgt = jalr_tgt;
               end else if (jal | take_branch) begin
                  pc_src  = SRC_BR;
                  sel_tgt = br_tgt;
               end else begin
                  pc_src  = SRC_SEQ;
                  sel_tgt = pc_plus4;
               end
               if (pc_src != SRC_SEQ && sel_tgt[1:0] != 2'b00) begin
                  state_d = S_FAULT;
               end else begin
                  pc_d      = sel_tgt;
                  instret_d = instret_q + CNT_W'(1);
               end
            end
         end
         S_HALT: begin
            if (resume) begin
               pc_src  = SRC_SEQ;
               pc_d    = pc_plus4;
               state_d = S_RUN;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_RUN;
         pc_q      <= RESET_VECTOR;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instret_q <= instret_d;
      end
   end

   assign pc      = pc_q;
   assign halted  = (state_q == S_HALT);
   assign fault   = (state_q == S_FAULT);
   assign instret = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a full-width and a 4-bit-counter instance share stimulus
// and are checked every cycle against an operand-level model plus literal pins.
module tb_pc_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        branch, jal, jalr, halt_req, resume;
   logic [2:0]  funct3;
   logic        zf, cf, vf, sf;
   logic [31:0] imm, rs1_data, op_a, op_b;

   logic [31:0] pc, pc_plus4, instret;
   logic [1:0]  pc_src;
   logic        take_branch, halted, fault;
   logic [31:0] s_pc, s_pp4;
   logic [1:0]  s_src;
   logic        s_take, s_halted, s_fault;
   logic [3:0]  s_instret;

   int passed = 0;
   int total  = 0;

   pc_sequencer #(.N(32), .RESET_VECTOR(32'h0), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .branch(branch), .jal(jal), .jalr(jalr), .halt_req(halt_req),
      .funct3(funct3), .zf(zf), .cf(cf), .vf(vf), .sf(sf), .imm(imm), .rs1_data(rs1_data),
      .resume(resume), .pc(pc), .pc_plus4(pc_plus4), .pc_src(pc_src),
      .take_branch(take_branch), .halted(halted), .fault(fault), .instret(instret));

   pc_sequencer #(.N(32), .RESET_VECTOR(32'h0), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .branch(branch), .jal(jal), .jalr(jalr), .halt_req(halt_req),
      .funct3(funct3), .zf(zf), .cf(cf), .vf(vf), .sf(sf), .imm(imm), .rs1_data(rs1_data),
      .resume(resume), .pc(s_pc), .pc_plus4(s_pp4), .pc_src(s_src),
      .take_branch(s_take), .halted(s_halted), .fault(s_fault), .instret(s_instret));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Flags as an ALU would produce them for rs1 - rs2 = a + ~b + 1.
   task automatic set_cmp(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] d;
      op_a = a;
      op_b = b;
      d  = {1'b0, a} + {1'b0, ~b} + 33'd1;
      cf = d[32];
      zf = (d[31:0] == 32'd0);
      sf = d[31];
      vf = (a[31] != b[31]) && (d[31] != a[31]);
   endtask

   task automatic idle();
      branch = 0; jal = 0; jalr = 0; halt_req = 0; resume = 0;
      funct3 = 3'b000; imm = 32'd0; rs1_data = 32'd0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Model: mode 0 = running, 1 = halted, 2 = faulted.
   logic [31:0] m_pc, m_cnt;
   int          m_st;
   logic        e_cond, e_take, e_bad;
   logic [1:0]  e_src;
   logic [31:0] e_tgt;

   always_comb begin
      case (funct3)
         3'b000:  e_cond = (op_a == op_b);
         3'b001:  e_cond = (op_a != op_b);
         3'b100:  e_cond = ($signed(op_a) <  $signed(op_b));
         3'b101:  e_cond = ($signed(op_a) >= $signed(op_b));
         3'b110:  e_cond = (op_a <  op_b);
         3'b111:  e_cond = (op_a >= op_b);
         default: e_cond = 1'b0;
      endcase
      e_take = 1'b0;
      e_src  = 2'b11;
      e_tgt  = m_pc;
      e_bad  = 1'b0;
      if (m_st == 0) begin
         e_take = branch && e_cond;
         if (halt_req)             e_src = 2'b11;
         else if (jalr)          begin e_src = 2'b01; e_tgt = (rs1_data + imm) & ~32'd1; end
         else if (jal || e_take) begin e_src = 2'b10; e_tgt = m_pc + imm; end
         else                    begin e_src = 2'b00; e_tgt = m_pc + 32'd4; end
         e_bad = (e_src == 2'b01 || e_src == 2'b10) && (e_tgt % 4 != 0);
      end else if (m_st == 1 && resume) begin
         e_src = 2'b00;
         e_tgt = m_pc + 32'd4;
      end
   end

   always @(posedge clk or posedge rst) begin
      logic [31:0] t;
      logic        bad;
      if (rst) begin
         m_pc = 32'd0; m_cnt = 32'd0; m_st = 0;
      end else begin
         t = e_tgt; bad = e_bad;
         if (m_st == 0) begin
            if (halt_req) begin m_st = 1; m_cnt = m_cnt + 1; end
            else if (bad) m_st = 2;
            else begin m_pc = t; m_cnt = m_cnt + 1; end
         end else if (m_st == 1 && resume) begin
            m_pc = t; m_st = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("pc", pc, m_pc);
         chk("pc_plus4", pc_plus4, m_pc + 32'd4);
         chk("pc_src", pc_src, e_src);
         chk("take_branch", take_branch, e_take);
         chk("halted", halted, m_st == 1);
         chk("fault", fault, m_st == 2);
         chk("instret", instret, m_cnt);
         chk("instret_w4", s_instret, m_cnt[3:0]);
         chk("pc_w4", s_pc, m_pc);
      end
   end

   task automatic pulse_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc_plus4", pc_plus4, 32'h4);
      chk("rst_halted", halted, 1'b0);
      chk("rst_fault", fault, 1'b0);
      chk("rst_instret", instret, 32'd0);
      @(negedge clk);
      #1 rst = 1'b0;
   endtask

   logic [31:0] pairs_a [5];
   logic [31:0] pairs_b [5];
   logic [31:0] cnt0;

   initial begin
      pairs_a = '{32'd5, 32'd5, 32'hFFFF_FFFD, 32'd2, 32'h8000_0000};
      pairs_b = '{32'd5, 32'd7, 32'd2, 32'hFFFF_FFFD, 32'd1};
      rst = 1'b1;
      idle();
      set_cmp(32'd0, 32'd0);
      #2;
      chk("rst_pc", pc, 32'h0);
      chk("rst_pc_plus4", pc_plus4, 32'h4);
      chk("rst_state", {halted, fault}, 2'b00);
      chk("rst_instret", instret, 32'd0);
      #10 rst = 1'b0;

      // Sequential fetch; resume while running must do nothing.
      repeat (3) cyc();
      resume = 1;
      cyc();
      resume = 0;
      chk("seq_pc", pc, 32'h10);
      chk("seq_instret", instret, 32'd4);

      // BLT taken from 0x10 back to 0x08.
      branch = 1; funct3 = 3'b100; imm = 32'hFFFF_FFF8;
      set_cmp(32'hFFFF_FFFF, 32'd0);
      #1;
      chk("blt_take", take_branch, 1'b1);
      chk("blt_src", pc_src, 2'b10);
      cyc();
      chk("blt_pc", pc, 32'h08);

      // BGEU not taken.
      funct3 = 3'b111; set_cmp(32'd1, 32'd2);
      #1;
      chk("bgeu_take", take_branch, 1'b0);
      chk("bgeu_src", pc_src, 2'b00);
      cyc();
      chk("bgeu_pc", pc, 32'h0C);

      // Every funct3 against signed/unsigned-sensitive operand pairs.
      imm = 32'd16;
      for (int f = 0; f < 8; f++) begin
         for (int p = 0; p < 5; p++) begin
            funct3 = f[2:0];
            set_cmp(pairs_a[p], pairs_b[p]);
            branch = (p != 4);
            cyc();
         end
      end
      idle();

      // JALR aligned, then misaligned -> FAULT with pc frozen.
      jalr = 1; rs1_data = 32'h101;
      cyc();
      chk("jalr_pc", pc, 32'h100);
      cnt0 = m_cnt;
      rs1_data = 32'h103;
      #1;
      chk("jalr_bad_src", pc_src, 2'b01);
      cyc();
      chk("jalr_fault", fault, 1'b1);
      chk("jalr_frozen", pc, 32'h100);
      chk("jalr_cnt", instret, cnt0);
      idle();
      resume = 1; jal = 1; imm = 32'd8;
      repeat (3) cyc();
      chk("fault_sticky", {fault, pc}, {1'b1, 32'h100});
      idle();
      pulse_reset();

      // jalr beats jal, then jump to 0x20 for halt.
      jalr = 1; jal = 1; rs1_data = 32'h201; imm = 32'd4;
      cyc();
      chk("jalr_win", pc, 32'h204);
      idle();
      jalr = 1; rs1_data = 32'h20;
      cyc();
      idle();
      cnt0 = m_cnt;
      halt_req = 1; jal = 1; imm = 32'd2;
      cyc();
      chk("halt_on", halted, 1'b1);
      chk("halt_pc", pc, 32'h20);
      chk("halt_cnt", instret, cnt0 + 32'd1);
      jal = 0; branch = 1; funct3 = 3'b000; set_cmp(32'd3, 32'd3); imm = 32'h40;
      repeat (3) cyc();
      chk("halt_hold", pc, 32'h20);
      resume = 1;
      cyc();
      chk("resume_pc", pc, 32'h24);
      chk("resume_halted", halted, 1'b0);
      chk("resume_cnt", instret, cnt0 + 32'd1);
      idle();

      // Counter wrap on the 4-bit instance: 17 retirements.
      pulse_reset();
      repeat (16) cyc();
      halt_req = 1;
      cyc();
      idle();
      chk("wrap_w4", s_instret, 4'd1);
      chk("wrap_w32", instret, 32'd17);
      chk("wrap_halted", halted, 1'b1);

      // Async reset between edges while halted.
      pulse_reset();
      repeat (2) cyc();
      chk("post_rst_pc", pc, 32'h8);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage of the single-cycle core. Holds the PC register and resolves the branch condition from ALU flags. Computes the PC+4, branch/JAL and JALR targets, and drives the 2-bit PC-source select consumed by the next-PC 4:1 mux. Adds a RUN/HALT/FAULT state machine and a retired-instruction counter, so halting, resuming and misaligned-target faults are handled in one place.

## Interface
- N, 32, datapath/address width
- RESET_VECTOR, 0, PC value after reset
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  reset, asynchronous and active-high
- branch  in  1  decoded conditional branch
- jal  in  1  decoded JAL
- jalr  in  1  decoded JALR
- halt_req  in  1  decoded halting instruction (ECALL/EBREAK/FENCE class)
- funct3  in  3  branch condition field
- zf, cf, vf, sf  in  1 each  ALU flags from rs1 − rs2 (computed as rs1 + ~rs2 + 1); cf=1 means rs1 ≥ rs2 unsigned
- imm  in  N  sign-extended immediate
- rs1_data  in  N  rs1 register value
- resume  in  1  single-cycle pulse, leave HALT
- pc  out  N  current PC (registered)
- pc_plus4  out  N  pc + 4, modulo 2^N
- pc_src  out  2  next-PC select: 00 PC+4, 10 branch/JAL target, 01 JALR target, 11 hold PC
- take_branch  out  1  branch condition true AND branch asserted
- halted  out  1  state == HALT
- fault  out  1  state == FAULT
- instret  out  CNT_W  retired-instruction count

## Operation
- Branch condition, evaluated on funct3:
  - 000: zf
  - 001: !zf
  - 100: sf != vf
  - 101: sf == vf
  - 110: !cf
  - 111: cf
  - 010 and 011: never taken
- Target computation:
  - branch/JAL target = pc + imm
  - JALR target = (rs1_data + imm) with bit 0 cleared
  - All sums truncate to N bits, and wrap-around is legal.
- States: RUN, HALT, FAULT. Reset state is RUN.
- In RUN, select priority is halt_req > jalr > (jal | take_branch) > PC+4.
- RUN, halt_req: pc_src=11, pc holds, next state HALT, instret += 1.
- RUN, jalr: pc_src=01.
- RUN, jal or take_branch: pc_src=10.
- RUN, otherwise: pc_src=00.
- Misaligned-target check in RUN:
  - Applies when pc_src is 10 or 01 and the selected target has bit 1 or bit 0 set.
  - Response: pc holds, instret unchanged, next state FAULT.
  - pc_src still shows the attempted select that cycle.
- Otherwise in RUN: pc ← selected value, instret += 1.
- HALT:
  - pc_src=11 and pc holds.
  - All decode inputs are ignored.
  - resume=1 → pc_src=00, pc ← pc_plus4, next state RUN, instret unchanged.
- FAULT:
  - pc_src=11, pc holds, and all inputs including resume are ignored.
  - Exit is by rst only.
- take_branch is forced to 0 outside RUN.
- resume in RUN or FAULT has no effect.
- instret wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous, immediate on rst high, independent of clk):
  - pc = RESET_VECTOR, state RUN, halted = 0, fault = 0, instret = 0.
  - pc_plus4 = RESET_VECTOR + 4.
- Reset mid-operation: rst high in any state forces the reset values above immediately.
- Release: the first PC update occurs on the first rising edge after rst falls.
- pc_src, take_branch and pc_plus4 are combinational from current inputs, state and pc. Their latency is zero within the cycle.
- pc, state and instret update on the rising edge. Latency is one cycle from select to the new pc.
- halted and fault are decoded directly from registered state. They assert in the cycle after the causing edge and are glitch-free.
- Simultaneous events:
  - halt_req with branch/jal/jalr: halt wins, and no misalignment check is made.
  - jalr with jal: jalr wins.
  - resume with halt_req while in HALT: resume wins, because halt_req is ignored in HALT.

## Test plan
- Sequential fetch:
  - Stimulus: RESET_VECTOR=0, no control asserted for 4 cycles.
  - Required: pc = 0, 4, 8, 12, 16, pc_src = 00, instret = 4.
- BLT taken:
  - Stimulus: pc=0x10, branch=1, funct3=100, sf=1, vf=0, imm=0xFFFFFFF8.
  - Required: take_branch=1, pc_src=10, next pc=0x08.
- BGEU not taken:
  - Stimulus: branch=1, funct3=111, cf=0.
  - Required: take_branch=0, pc_src=00, next pc = pc+4.
- JALR:
  - Stimulus: rs1_data=0x103, imm=0x0, jalr=1.
  - Required: target 0x102 → misaligned, fault=1 next cycle, pc frozen, instret unchanged.
  - Repeat with rs1_data=0x101: required next pc=0x100, no fault.
- Halt/resume:
  - Stimulus: halt_req at pc=0x20, then hold 3 cycles with branch=1, taken flags, and imm=0x40.
  - Required: halted=1, pc stays 0x20, pc_src=11, instret +1.
  - Then resume pulse: required pc=0x24, halted=0.
- Async reset mid-HALT, plus wrap:
  - Stimulus: assert rst between edges while in HALT.
  - Required: pc=RESET_VECTOR and halted=0 immediately.
  - Stimulus: CNT_W=4, run 17 instructions.
  - Required: instret=1.
